// File: rtl/normalize_w_vec.sv
// Scales a 2-element signed weight vector so its largest-magnitude element becomes +/-1.0.
// One restoring divider, sequenced IDLE -> LOAD -> DIV -> DONE, produces the other element's ratio.
module normalize_w_vec #(
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic                I_sys_clk,
    input  logic                I_sys_rstn,
    input  logic                I_start,
    input  logic signed [W-1:0] I_w_1_1,
    input  logic signed [W-1:0] I_w_2_1,
    output logic                O_busy,
    output logic                O_valid,
    output logic                O_err,
    output logic signed [W-1:0] O_w_1_1_normalize,
    output logic signed [W-1:0] O_w_2_1_normalize
);

    localparam int CW = $clog2(FRAC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAC);
    localparam logic [FRAC:0] ONE_MAG  = {1'b1, {FRAC{1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

    // Magnitude in W+1 bits so that the most negative input still has a representable |x|.
    function automatic logic [W:0] abs_ext(input logic signed [W-1:0] x);
        logic signed [W:0] xe;
        xe = {x[W-1], x};
        return (x < 0) ? -xe : xe;
    endfunction

    // Applies the input's sign to an unsigned magnitude; zero stays +0.
    function automatic logic signed [W-1:0] apply_sign(input logic [FRAC:0] mag, input logic neg);
        logic signed [W-1:0] m;
        m = {{(W-FRAC-1){1'b0}}, mag};
        return (neg && (mag != '0)) ? -m : m;
    endfunction

    state_t              state_q, state_d;
    logic signed [W-1:0] w1_q, w1_d, w2_q, w2_d;
    logic [W:0]          dvs_q, dvs_d, rem_q, rem_d;
    logic [FRAC:0]       sh_q, sh_d, quo_q, quo_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                piv2_q, piv2_d, err_q, err_d;
    logic                valid_q, valid_d, oerr_q, oerr_d;
    logic signed [W-1:0] o1_q, o1_d, o2_q, o2_d;

    logic [W:0]   a1, a2, piv_mag, oth_mag;
    logic         piv2, both_zero, ge;
    logic [W+1:0] trial, tdiff;

    always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
        if (!I_sys_rstn) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (I_start) state_d = LOAD;
            LOAD:    state_d = both_zero ? DONE : DIV;
            DIV:     if (cnt_q == CNT_LAST) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        O_busy = (state_q != IDLE);
    end

    always_comb begin
        a1        = abs_ext(w1_q);
        a2        = abs_ext(w2_q);
        piv2      = (a2 > a1);
        piv_mag   = piv2 ? a2 : a1;
        oth_mag   = piv2 ? a1 : a2;
        both_zero = (w1_q == '0) && (w2_q == '0);
        trial     = {rem_q, sh_q[FRAC]};
        tdiff     = trial - {1'b0, dvs_q};
        ge        = (trial >= {1'b0, dvs_q});

        w1_d    = w1_q;
        w2_d    = w2_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        piv2_d  = piv2_q;
        err_d   = err_q;
        valid_d = 1'b0;
        oerr_d  = oerr_q;
        o1_d    = o1_q;
        o2_d    = o2_q;

        case (state_q)
            IDLE: begin
                if (I_start) begin
                    w1_d = I_w_1_1;
                    w2_d = I_w_2_1;
                end
            end
            LOAD: begin
                // |other| <= |pivot|, so the bits above the quotient MSB (|other|>>1) are below the divisor.
                piv2_d = piv2;
                err_d  = both_zero;
                dvs_d  = piv_mag;
                rem_d  = oth_mag >> 1;
                sh_d   = {oth_mag[0], {FRAC{1'b0}}};
                quo_d  = '0;
                cnt_d  = '0;
            end
            DIV: begin
                rem_d = ge ? tdiff[W:0] : trial[W:0];
                quo_d = {quo_q[FRAC-1:0], ge};
                sh_d  = {sh_q[FRAC-1:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
            end
            default: begin
                valid_d = 1'b1;
                oerr_d  = err_q;
                if (err_q) begin
                    o1_d = '0;
                    o2_d = '0;
                end else if (piv2_q) begin
                    o1_d = apply_sign(quo_q, w1_q[W-1]);
                    o2_d = apply_sign(ONE_MAG, w2_q[W-1]);
                end else begin
                    o1_d = apply_sign(ONE_MAG, w1_q[W-1]);
                    o2_d = apply_sign(quo_q, w2_q[W-1]);
                end
            end
        endcase
    end

    always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
        if (!I_sys_rstn) begin
            w1_q    <= '0;
            w2_q    <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            sh_q    <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            piv2_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            oerr_q  <= 1'b0;
            o1_q    <= '0;
            o2_q    <= '0;
        end else begin
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            piv2_q  <= piv2_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            oerr_q  <= oerr_d;
            o1_q    <= o1_d;
            o2_q    <= o2_d;
        end
    end

    assign O_valid           = valid_q;
    assign O_err             = oerr_q;
    assign O_w_1_1_normalize = o1_q;
    assign O_w_2_1_normalize = o2_q;

endmodule

// File: tb/tb_normalize_w_vec.sv
// Scoreboard bench for normalize_w_vec: directed vectors, protocol/reset cases and random pairs
// against an integer reference model.
module tb_normalize_w_vec;
    localparam int W    = 32;
    localparam int FRAC = 16;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                start = 1'b0;
    logic signed [W-1:0] w1 = '0, w2 = '0;
    logic                busy, valid, err;
    logic signed [W-1:0] o1, o2;

    normalize_w_vec #(.W(W), .FRAC(FRAC)) dut (
        .I_sys_clk(clk), .I_sys_rstn(rstn), .I_start(start),
        .I_w_1_1(w1), .I_w_2_1(w2),
        .O_busy(busy), .O_valid(valid), .O_err(err),
        .O_w_1_1_normalize(o1), .O_w_2_1_normalize(o2)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [W-1:0] e1;
        logic signed [W-1:0] e2;
        logic                err;
        int unsigned         st;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: every O_valid must match the oldest outstanding request.
    always @(negedge clk) begin
        if (valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'(valid), 32'd0);
            end else begin
                got = sb.pop_front();
                chk("o_w_1_1", o1, got.e1);
                chk("o_w_2_1", o2, got.e2);
                chk("o_err", 32'(err), 32'(got.err));
                if (got.err)
                    chk("err_latency_le3", 32'((cyc - got.st) >= 2 && (cyc - got.st) <= 3), 32'd1);
                else
                    chk("latency", cyc - got.st, 32'(FRAC + 3));
            end
        end
    end

    function automatic exp_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic e);
        exp_t r;
        r.e1 = a; r.e2 = b; r.err = e; r.st = 0;
        return r;
    endfunction

    function automatic exp_t model(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        exp_t   r;
        longint ma, mb, mp, mo, q, pv, ov;
        logic   p2;
        r.st = 0;
        ma = (a < 0) ? -longint'(a) : longint'(a);
        mb = (b < 0) ? -longint'(b) : longint'(b);
        if (ma == 0 && mb == 0) begin
            r.e1 = '0; r.e2 = '0; r.err = 1'b1;
            return r;
        end
        p2 = (mb > ma);
        mp = p2 ? mb : ma;
        mo = p2 ? ma : mb;
        q  = (mo << FRAC) / mp;
        pv = ((p2 ? b : a) < 0) ? -(longint'(1) << FRAC) : (longint'(1) << FRAC);
        ov = ((p2 ? a : b) < 0) ? -q : q;
        r.e1  = p2 ? ov[W-1:0] : pv[W-1:0];
        r.e2  = p2 ? pv[W-1:0] : ov[W-1:0];
        r.err = 1'b0;
        return r;
    endfunction

    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
        w1 = a;
        w2 = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        exp_t x;
        x = e;
        x.st = cyc + 1;
        sb.push_back(x);
        drive_start(a, b);
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_drain();
    endtask

    logic signed [W-1:0] h1, h2;
    logic                herr, stable;
    logic signed [W-1:0] ra, rb;
    exp_t                t1;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_o1", o1, 32'd0);
        chk("rst_o2", o2, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        t1 = mk(32'h0001_0000, 32'h0000_8000, 1'b0);
        do_op(32'h0002_0000, 32'h0001_0000, t1);
        do_op(32'hFFFD_0000, 32'h0006_0000, mk(32'hFFFF_8000, 32'h0001_0000, 1'b0));
        do_op(32'h0001_0000, 32'h0003_0000, mk(32'h0000_5555, 32'h0001_0000, 1'b0));
        do_op(32'h0003_0000, 32'hFFFD_0000, mk(32'h0001_0000, 32'hFFFF_0000, 1'b0));
        do_op(32'h8000_0000, 32'h4000_0000, mk(32'hFFFF_0000, 32'h0000_8000, 1'b0));
        do_op(32'h0000_0000, 32'h0000_0000, mk(32'h0, 32'h0, 1'b1));
        do_op(32'h0000_0000, 32'hFFFF_FFFF, mk(32'h0, 32'hFFFF_0000, 1'b0));

        // Second start while busy must be dropped; results then hold through idle.
        t1.st = cyc + 1;
        sb.push_back(t1);
        drive_start(32'h0002_0000, 32'h0001_0000);
        repeat (3) @(negedge clk);
        drive_start(32'h7FFF_0000, 32'hFFFF_FFFF);
        wait_drain();
        h1 = o1; h2 = o2; herr = err; stable = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (o1 !== h1 || o2 !== h2 || err !== herr || valid !== 1'b0) stable = 1'b0;
        end
        chk("hold_100", 32'(stable), 32'd1);
        chk("hold_o1", o1, 32'h0001_0000);

        // Reset in the middle of a divide aborts it with no late O_valid.
        t1 = mk(32'hFFFF_8000, 32'h0001_0000, 1'b0);
        t1.st = cyc + 1;
        sb.push_back(t1);
        drive_start(32'hFFFD_0000, 32'h0006_0000);
        repeat (8) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_o1", o1, 32'd0);
        chk("midrst_o2", o2, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        do_op(32'h0001_0000, 32'h0003_0000, mk(32'h0000_5555, 32'h0001_0000, 1'b0));

        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 4))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $signed($urandom_range(0, 32'h001F_FFFF)) - 32'sh0010_0000;
                         rb = $signed($urandom_range(0, 32'h001F_FFFF)) - 32'sh0010_0000; end
                2: begin ra = $urandom; rb = ($urandom_range(0, 1) == 0) ? ra : -ra; end
                3: begin ra = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF; rb = $urandom; end
                default: begin ra = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom; rb = 32'h0; end
            endcase
            if ($urandom_range(0, 1) == 1) begin
                {ra, rb} = {rb, ra};
            end
            do_op(ra, rb, model(ra, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
